vecmac_seq: RTL and testbench
=============================

# vecmac_seq

Sequencer for the 4-lane int8 multiplier `mul4x8x8_wallace`, turning it into an unsigned dot-product engine.
- Accepts a stream of 32-bit operand beats (four 8-bit lanes each); the last beat of a vector is flagged.
- Issues one beat per cycle to the multiplier and reduces the four 16-bit lane products into a 32-bit accumulator.
- Presents one result per vector on a valid/ready output.
- Sits between the operand fetch path and result writeback in the int8 vector-MAC datapath.

## Interface
Parameters:
- `ACC_W`, 32: accumulator and result width.
- `CNT_W`, 16: beat-counter width.
- `MUL_LAT`, 3: edges from beat acceptance to the edge that registers its product.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: operand beat valid.
- `s_ready` out 1: beat accepted at an edge where `s_valid && s_ready`.
- `s_a` in 32: lanes {a3,a2,a1,a0}, unsigned 8-bit each.
- `s_b` in 32: lanes {b3,b2,b1,b0}.
- `s_last` in 1: beat is the final beat of its vector.
- `m_valid` out 1: result valid.
- `m_ready` in 1: result consumed at an edge where `m_valid && m_ready`.
- `m_sum` out `ACC_W`: Σ over beats of a0·b0+a1·b1+a2·b2+a3·b3, modulo 2^ACC_W.
- `m_count` out `CNT_W`: beats in the vector, saturating at all-ones.
- `m_ovf` out 1: accumulation wrapped at least once in this vector.
- `busy` out 1: state ≠ IDLE.

## Operation
FSM states:
- IDLE: reset state, `s_ready=1`, accumulator = 0.
  - Non-last beat accepted → ACCUM.
  - Last beat accepted → DRAIN.
- ACCUM: `s_ready=1`. Last beat accepted → DRAIN.
- DRAIN: `s_ready=0`. Waits until the last beat's product has been registered, then → DONE.
- DONE: `m_valid=1`, `s_ready=0`. On handshake → IDLE; accumulator, count and overflow flag clear.

Datapath:
- Multiplier connections are combinational: `in_valid = s_valid && s_ready`, `in_a = s_a`, `in_b = s_b`.
- The multiplier is fully pipelined and accepts a beat every cycle.
- A `MUL_LAT`-deep shift register carries the valid and last tags alongside the in-flight beats.
- Each edge with multiplier `out_valid` high:
  - acc ← acc + zero-extended sum of the four 16-bit lanes (18-bit lane sum).
  - A carry out of bit `ACC_W-1` sets the sticky overflow flag; the sum wraps.
- When the tagged last product is registered, `m_sum`, `m_count` and `m_ovf` load in the same edge.
- Outputs hold stable while `m_valid && !m_ready`.
- No new vector is accepted until its predecessor's result is handed off; vectors never interleave.
- `m_count` increments per accepted beat and saturates rather than wrapping.
- Multiplier reset: `rst_n = ~rst`, so in-flight products are discarded on reset.

## Timing
- Reset values: `s_ready=1`, `m_valid=0`, `m_sum=0`, `m_count=0`, `m_ovf=0`, `busy=0`, state IDLE.
- Reset takes priority over every other event, including mid-vector, in DRAIN, and in DONE with a pending result. The partial vector is dropped and no result is produced.
- Latency: last beat accepted at edge t → `m_valid` high from edge t+`MUL_LAT`.
  - The multiplier asserts `out_valid` after edge t+2.
  - Its product is registered at edge t+3.
- Throughput: one beat per cycle within a vector. Inter-vector gap is `MUL_LAT` + 1 cycles minimum, with `m_ready` held high.
- `s_ready` falls the cycle after the last beat is accepted.
- `s_ready` rises the cycle after the output handshake.
- `m_ready` high while `m_valid` is low has no effect.
- `s_valid` is ignored while `s_ready` is low.
- The source must hold `s_a`, `s_b` and `s_last` stable while `s_valid && !s_ready`.

## Structure
- Package `vecmac_pkg`:
  - FSM state enum {IDLE, ACCUM, DRAIN, DONE}.
  - Constants: lane count (4), lane width (8), product width (16), lane-sum width (18), default `MUL_LAT` (3).
- One sub-module: the existing `mul4x8x8_wallace`, instantiated unchanged.
- Tag shift register, lane-sum reduction and FSM stay inline.

## Test plan
- Single beat, `s_a=32'h04030201`, `s_b=32'h01010101`, last=1, accepted at edge t → `m_valid` at edge t+3, `m_sum=10`, `m_count=1`, `m_ovf=0`.
- Single beat, all lanes 0xFF → `m_sum=32'h0003F804` (260100).
- Three back-to-back beats (`s_a=32'h01010101`, `s_b` lanes all 2, 3, 4) → `s_ready` stays high across all three; `m_sum=36`, `m_count=3`.
- Result backpressure: `m_ready` low for 5 cycles after `m_valid` →
  - `m_sum`/`m_count` stable, `s_ready` low, pending `s_valid` beat not taken.
  - Beat accepted the cycle after the handshake.
- Overflow: 16513 beats of all-0xFF lanes → `m_sum=32'h0000FA04`, `m_ovf=1`, `m_count=16513`.
- `rst` pulsed one cycle in DRAIN →
  - No `m_valid` ever.
  - All outputs return to reset values the next cycle.
  - The next 1-beat vector yields a correct, uncontaminated sum.

Source files
------------

// File: rtl/vecmac_pkg.sv
// Shared types and constants for the int8 vector-MAC sequencer.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package vecmac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int LANES       = 4;
  localparam int LANE_W      = 8;
  localparam int PROD_W      = 16;
  localparam int LSUM_W      = 18;
  localparam int MUL_LAT_DEF = 3;

  // Adds the four 16-bit lane products; 18 bits cannot overflow (4 * 65025).
  function automatic logic [LSUM_W-1:0] lane_sum(input logic [LANES*PROD_W-1:0] p);
    logic [LSUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      s = s + LSUM_W'(p[i*PROD_W +: PROD_W]);
    end
    return s;
  endfunction

endpackage

// File: rtl/mul4x8x8_wallace.sv
// Four independent unsigned 8x8 multipliers, fully pipelined, one beat per cycle.
// Latency: 3 edges from in_valid sampled to out_valid/out_p registered.
// Backpressure: none; accepts every cycle, caller must consume every output.
module mul4x8x8_wallace
  import vecmac_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [LANES*LANE_W-1:0] in_a,
  input  logic [LANES*LANE_W-1:0] in_b,
  output logic                    out_valid,
  output logic [LANES*PROD_W-1:0] out_p
);

  logic [LANES*LANE_W-1:0] a_q, b_q;
  logic                    v1_q, v2_q, v3_q;
  logic [LANES-1:0][11:0]  lo_q, hi_q;
  logic [LANES*PROD_W-1:0] p_q;

  // Stage 1: register operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      a_q  <= in_a;
      b_q  <= in_b;
      v1_q <= in_valid;
    end
  end

  // Stage 2: per lane, split b into nibbles and form two 8x4 partial sums.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_q <= '0;
      hi_q <= '0;
      v2_q <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        lo_q[i] <= {4'b0, a_q[i*LANE_W +: LANE_W]} * {8'b0, b_q[i*LANE_W +: 4]};
        hi_q[i] <= {4'b0, a_q[i*LANE_W +: LANE_W]} * {8'b0, b_q[i*LANE_W+4 +: 4]};
      end
      v2_q <= v1_q;
    end
  end

  // Stage 3: final carry-propagate add of the shifted partial sums.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q  <= '0;
      v3_q <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        p_q[i*PROD_W +: PROD_W] <= PROD_W'(lo_q[i]) + {hi_q[i], 4'b0};
      end
      v3_q <= v2_q;
    end
  end

  assign out_valid = v3_q;
  assign out_p     = p_q;

endmodule

// File: rtl/vecmac_seq.sv
// Unsigned int8 dot-product sequencer around the 4-lane multiplier.
// Latency: last beat accepted at edge t -> m_valid from edge t+MUL_LAT.
// Backpressure: s_ready low from last beat until result handshake; outputs hold while m_ready low.
module vecmac_seq
  import vecmac_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int CNT_W   = 16,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [LANES*LANE_W-1:0] s_a,
  input  logic [LANES*LANE_W-1:0] s_b,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ACC_W-1:0]        m_sum,
  output logic [CNT_W-1:0]        m_count,
  output logic                    m_ovf,
  output logic                    busy
);

  state_e                  state_q, state_d;
  logic [MUL_LAT-1:0]      tag_vld_q, tag_last_q;
  logic [ACC_W-1:0]        acc_q, acc_d, sum_q, sum_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, mcnt_q, mcnt_d;
  logic                    ovf_q, ovf_d, movf_q, movf_d;
  logic                    beat_acc, mul_vld, last_done, handoff;
  logic [LANES*PROD_W-1:0] mul_p;
  logic [LSUM_W-1:0]       lsum;
  logic [ACC_W:0]          acc_ext;

  assign s_ready   = (state_q == IDLE) || (state_q == ACCUM);
  assign m_valid   = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign beat_acc  = s_valid && s_ready;
  assign handoff   = m_valid && m_ready;
  assign last_done = tag_vld_q[MUL_LAT-1] && tag_last_q[MUL_LAT-1];

  mul4x8x8_wallace u_mul (
    .clk       (clk),
    .rst_n     (~rst),
    .in_valid  (beat_acc),
    .in_a      (s_a),
    .in_b      (s_b),
    .out_valid (mul_vld),
    .out_p     (mul_p)
  );

  assign lsum    = lane_sum(mul_p);
  assign acc_ext = {1'b0, acc_q} + (ACC_W+1)'(lsum);

  // Tag pipeline: valid/last travel alongside each beat inside the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q  <= '0;
      tag_last_q <= '0;
    end else begin
      tag_vld_q[0]  <= beat_acc;
      tag_last_q[0] <= beat_acc && s_last;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
    end
  end

  // FSM next state: one vector in flight at a time, result must drain before the next.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat_acc) state_d = s_last ? DRAIN : ACCUM;
      ACCUM:   if (beat_acc && s_last) state_d = DRAIN;
      DRAIN:   if (last_done) state_d = DONE;
      DONE:    if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulate products, count beats (saturating), snapshot result on the last product.
  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    mcnt_d = mcnt_q;
    movf_d = movf_q;
    if (mul_vld) begin
      acc_d = acc_ext[ACC_W-1:0];
      ovf_d = ovf_q | acc_ext[ACC_W];
    end
    if (beat_acc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (last_done) begin
      sum_d  = acc_ext[ACC_W-1:0];
      movf_d = ovf_q | acc_ext[ACC_W];
      mcnt_d = cnt_q;
    end
    // Handoff and further products never coincide: DONE is only reached once the pipe is empty.
    if (handoff) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end
  end

  // State and datapath registers; reset drops any partial vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      mcnt_q  <= '0;
      movf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      mcnt_q  <= mcnt_d;
      movf_q  <= movf_d;
    end
  end

  assign m_sum   = sum_q;
  assign m_count = mcnt_q;
  assign m_ovf   = movf_q;

endmodule

// File: tb/tb_vecmac_seq.sv
// Self-checking bench for vecmac_seq: directed and random vectors vs an arithmetic model.
// Latency: checks m_valid exactly MUL_LAT edges after the last beat.
// Backpressure: exercises held results, pending beats, and reset while draining.
module tb_vecmac_seq;

  localparam int ACC_W   = 32;
  localparam int CNT_W   = 16;
  localparam int MUL_LAT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid, s_ready, s_last;
  logic [31:0]      s_a, s_b;
  logic             m_valid, m_ready, m_ovf, busy;
  logic [ACC_W-1:0] m_sum;
  logic [CNT_W-1:0] m_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] va[$];
  logic [31:0] vb[$];

  vecmac_seq #(.ACC_W(ACC_W), .CNT_W(CNT_W), .MUL_LAT(MUL_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_a     (s_a),
    .s_b     (s_b),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_sum   (m_sum),
    .m_count (m_count),
    .m_ovf   (m_ovf),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: dot product as plain wide arithmetic over the queued vector.
  task automatic model(output logic [31:0] es, output logic [15:0] ec, output logic eo);
    longint t;
    int     n;
    t = 0;
    foreach (va[i]) begin
      for (int l = 0; l < 4; l++) begin
        t += longint'(va[i][8*l +: 8]) * longint'(vb[i][8*l +: 8]);
      end
    end
    n  = va.size();
    es = t[31:0];
    eo = (t >= 64'h1_0000_0000);
    ec = (n > 65535) ? 16'hFFFF : 16'(n);
  endtask

  task automatic send_vec(output int stalls, output int last_edge);
    int   g;
    logic took;
    stalls = 0;
    foreach (va[i]) begin
      s_valid = 1'b1;
      s_a     = va[i];
      s_b     = vb[i];
      s_last  = (i == va.size() - 1);
      g = 0;
      do begin
        took = s_ready;
        if (!took) stalls++;
        tick();
        g++;
      end while (!took && g < 100);
      if (!took) chk("accept_timeout", 0, 1);
    end
    last_edge = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic finish_vec(input int last_edge, input int hold, input bit early, input string tag);
    logic [31:0] es;
    logic [15:0] ec;
    logic        eo;
    int          g;
    model(es, ec, eo);
    if (early) m_ready = 1'b1;
    g = 0;
    while (!m_valid && g < 50) begin
      tick();
      g++;
    end
    chk({tag, "_valid"}, m_valid, 1);
    chk({tag, "_lat"}, cyc - last_edge, MUL_LAT);
    chk({tag, "_sum"}, m_sum, es);
    chk({tag, "_cnt"}, m_count, ec);
    chk({tag, "_ovf"}, m_ovf, eo);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold"}, {m_valid, s_ready, m_sum, m_count}, {1'b1, 1'b0, es, ec});
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk({tag, "_release"}, {m_valid, s_ready, busy}, 3'b010);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {s_ready, m_valid, m_sum, m_count, m_ovf, busy},
        {1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0});
  endtask

  initial begin
    int          st, le, seen;
    logic [31:0] pa, pb;

    rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) tick();
    chk_reset_vals("reset_state");
    rst = 1'b0;
    tick();

    // Single beat, lane products 1+2+3+4.
    va = '{32'h04030201}; vb = '{32'h01010101};
    send_vec(st, le);
    finish_vec(le, 0, 0, "single");

    // Single beat, all lanes at maximum.
    va = '{32'hFFFFFFFF}; vb = '{32'hFFFFFFFF};
    send_vec(st, le);
    finish_vec(le, 0, 0, "allff");

    // Three back-to-back beats, no stall allowed.
    va = '{32'h01010101, 32'h01010101, 32'h01010101};
    vb = '{32'h02020202, 32'h03030303, 32'h04040404};
    send_vec(st, le);
    chk("b2b_stalls", st, 0);
    finish_vec(le, 0, 0, "b2b");

    // Result held for 5 cycles with a beat pending on the input.
    va = '{$urandom}; vb = '{$urandom};
    send_vec(st, le);
    pa = $urandom; pb = $urandom;
    s_valid = 1'b1; s_a = pa; s_b = pb; s_last = 1'b1;
    finish_vec(le, 5, 0, "bp");
    va = '{pa}; vb = '{pb};
    send_vec(st, le);
    chk("bp_next_stalls", st, 0);
    finish_vec(le, 0, 0, "bp_next");

    // Overflow: 16513 max beats wrap the 32-bit accumulator once.
    va = {}; vb = {};
    for (int i = 0; i < 16513; i++) begin
      va.push_back(32'hFFFFFFFF);
      vb.push_back(32'hFFFFFFFF);
    end
    send_vec(st, le);
    finish_vec(le, 0, 1, "ovf");

    // Reset pulsed while draining: nothing comes out, state fully clean.
    va = '{$urandom}; vb = '{$urandom};
    send_vec(st, le);
    chk("drain_state", {busy, s_ready}, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("rst_drain");
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_valid) seen++;
    end
    chk("rst_no_valid", seen, 0);
    va = '{$urandom}; vb = '{$urandom};
    send_vec(st, le);
    finish_vec(le, 0, 0, "post_rst");

    // Random vectors with random length, hold and early ready.
    for (int v = 0; v < 8; v++) begin
      int n;
      n = $urandom_range(1, 8);
      va = {}; vb = {};
      for (int i = 0; i < n; i++) begin
        va.push_back($urandom);
        vb.push_back($urandom);
      end
      send_vec(st, le);
      chk("rand_stalls", st, 0);
      if ($urandom_range(0, 1) == 1) finish_vec(le, 0, 1, "rand_early");
      else finish_vec(le, $urandom_range(0, 3), 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
